// File: rtl/tlc_sensor_timer_pkg.sv
// -----------------------------------------------------------------------------
// tlc_sensor_timer_pkg
// Shared types and defaults for the traffic-light sensor/timer stage.
//   phase_t       : light phase decoded from the FSM lamp feedback
//   DEF_*         : default timing limits in clock cycles
//   phase_decode  : lamp feedback -> phase, HGREEN has the highest priority
// Optional feature macro used by the top level: TLC_MAX_GREEN_EN
// -----------------------------------------------------------------------------
package tlc_sensor_timer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_GREEN,
        PH_HYEL,
        PH_HLEFT,
        PH_FLEFT,
        PH_FYEL
    } phase_t;

    localparam int unsigned DEF_DEB_CYCLES = 16;
    localparam int unsigned DEF_GREEN_MIN  = 1000;
    localparam int unsigned DEF_YELLOW_CYC = 200;
    localparam int unsigned DEF_HLEFT_CYC  = 300;
    localparam int unsigned DEF_FLEFT_CYC  = 400;
    localparam int unsigned DEF_MAX_GREEN  = 4000;
    localparam int unsigned DEF_CNT_W      = 16;

    function automatic phase_t phase_decode(input logic hgreen,
                                            input logic hyellow,
                                            input logic hleft,
                                            input logic fleft,
                                            input logic fyellow);
        phase_t ph;
        if (hgreen)       ph = PH_GREEN;
        else if (hyellow) ph = PH_HYEL;
        else if (hleft)   ph = PH_HLEFT;
        else if (fleft)   ph = PH_FLEFT;
        else if (fyellow) ph = PH_FYEL;
        else              ph = PH_IDLE;
        return ph;
    endfunction

endpackage

// File: rtl/tlc_sensor_timer_if.sv
// -----------------------------------------------------------------------------
// tlc_sensor_timer_if
// Signal bundle between the sensor/timer stage and its surroundings.
//   HWY_CAR_RAW, FARM_CAR_RAW : raw, asynchronous, bouncing car sensors
//   HGREEN..FYELLOW           : lamp feedback from the traffic-light FSM
//   HS, FS                    : advance requests to the FSM
//   FARM_PENDING              : latched farm request (debug)
// modport master : the side that drives sensors/lamps and consumes HS/FS
// modport slave  : the sensor/timer stage itself
// -----------------------------------------------------------------------------
interface tlc_sensor_timer_if;

    logic HWY_CAR_RAW;
    logic FARM_CAR_RAW;
    logic HGREEN;
    logic HYELLOW;
    logic HLEFT;
    logic FLEFT;
    logic FYELLOW;
    logic HS;
    logic FS;
    logic FARM_PENDING;

    modport master (
        output HWY_CAR_RAW, FARM_CAR_RAW,
        output HGREEN, HYELLOW, HLEFT, FLEFT, FYELLOW,
        input  HS, FS, FARM_PENDING
    );

    modport slave (
        input  HWY_CAR_RAW, FARM_CAR_RAW,
        input  HGREEN, HYELLOW, HLEFT, FLEFT, FYELLOW,
        output HS, FS, FARM_PENDING
    );

endinterface

// File: rtl/tlc_sensor_timer_debounce.sv
// -----------------------------------------------------------------------------
// tlc_debounce
// Two-flop synchronizer followed by a debounce counter. The output level
// follows the synchronized input only after DEB_CYCLES consecutive samples
// that differ from the current level; any sample equal to the current level
// restarts the count. Raw-to-level latency is 2+DEB_CYCLES cycles.
//   CLOCK  in  system clock
//   RESET  in  asynchronous active-high reset
//   raw    in  asynchronous sensor input
//   level  out debounced level (registered)
// -----------------------------------------------------------------------------
module tlc_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic raw,
    output logic level
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt_q   <= '0;
            level   <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            if (sync_q2 == level) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level <= sync_q2;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_sensor_timer.sv
// -----------------------------------------------------------------------------
// tlc_sensor_timer
// Upstream stage of the traffic-light FSM: debounces the highway and farm
// sensors, latches farm requests and times each light phase from the lamp
// feedback, producing the HS/FS advance requests.
//   CLOCK  in   system clock, rising edge
//   RESET  in   asynchronous active-high reset
//   bus    slave modport of tlc_sensor_timer_if (sensors, lamps, HS/FS,
//          FARM_PENDING)
// Optional feature: define TLC_MAX_GREEN_EN to force HS in highway green
// once the phase counter reaches MAX_GREEN, even with no highway car.
// -----------------------------------------------------------------------------
module tlc_sensor_timer
    import tlc_sensor_timer_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned GREEN_MIN  = DEF_GREEN_MIN,
    parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int unsigned HLEFT_CYC  = DEF_HLEFT_CYC,
    parameter int unsigned FLEFT_CYC  = DEF_FLEFT_CYC,
    parameter int unsigned MAX_GREEN  = DEF_MAX_GREEN,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic               CLOCK,
    input  logic               RESET,
    tlc_sensor_timer_if.slave  bus
);

`ifdef TLC_MAX_GREEN_EN
    localparam bit MAX_GREEN_EN = 1'b1;
`else
    localparam bit MAX_GREEN_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LIM_GREEN = CNT_W'(GREEN_MIN);
    localparam logic [CNT_W-1:0] LIM_YEL   = CNT_W'(YELLOW_CYC);
    localparam logic [CNT_W-1:0] LIM_HLEFT = CNT_W'(HLEFT_CYC);
    localparam logic [CNT_W-1:0] LIM_FLEFT = CNT_W'(FLEFT_CYC);
    localparam logic [CNT_W-1:0] LIM_MAXG  = CNT_W'(MAX_GREEN);

    logic             hwy_db;
    logic             farm_db;
    logic             farm_prev_q;
    logic             pending_q;
    logic             farm_rise;
    logic             pending;

    phase_t           phase_d;
    phase_t           phase_q;
    logic             same_phase;
    logic [CNT_W-1:0] counter_q;
    logic [CNT_W-1:0] limit;
    logic             has_limit;
    logic             done;
    logic             max_green_hit;

    tlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hwy_deb (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .raw   (bus.HWY_CAR_RAW),
        .level (hwy_db)
    );

    tlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_farm_deb (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .raw   (bus.FARM_CAR_RAW),
        .level (farm_db)
    );

    always_comb begin
        phase_d = phase_decode(bus.HGREEN, bus.HYELLOW, bus.HLEFT,
                               bus.FLEFT, bus.FYELLOW);
    end

    assign same_phase = (phase_d == phase_q);

    // The rising edge of the debounced farm level is visible in the same
    // cycle the level changes; pending_q holds it from the next edge on.
    assign farm_rise = farm_db & ~farm_prev_q;
    assign pending   = pending_q | farm_rise;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            phase_q     <= PH_IDLE;
            counter_q   <= '0;
            farm_prev_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            farm_prev_q <= farm_db;

            if (!same_phase) begin
                counter_q <= '0;
            end else if (counter_q != '1) begin
                counter_q <= counter_q + 1'b1;
            end

            // A new request arriving on the FLEFT exit cycle survives.
            if (farm_rise) begin
                pending_q <= 1'b1;
            end else if (phase_q == PH_FLEFT && phase_d != PH_FLEFT) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        limit     = '1;
        has_limit = 1'b1;
        case (phase_q)
            PH_GREEN: limit = LIM_GREEN;
            PH_HYEL:  limit = LIM_YEL;
            PH_HLEFT: limit = LIM_HLEFT;
            PH_FLEFT: limit = LIM_FLEFT;
            PH_FYEL:  limit = LIM_YEL;
            default:  has_limit = 1'b0;
        endcase
    end

    // Gating by same_phase keeps a stale request off the lamp-change cycle.
    assign done          = same_phase & has_limit & (counter_q >= limit);
    assign max_green_hit = MAX_GREEN_EN & (phase_q == PH_GREEN) &
                           (counter_q >= LIM_MAXG);

    assign bus.HS           = done & ((phase_q != PH_GREEN) | hwy_db | max_green_hit);
    assign bus.FS           = done & pending;
    assign bus.FARM_PENDING = pending;

endmodule

// File: tb/tb_tlc_sensor_timer.sv
// -----------------------------------------------------------------------------
// tb_tlc_sensor_timer
// Self-checking bench for tlc_sensor_timer with short timing parameters.
// Honours TLC_MAX_GREEN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_tlc_sensor_timer;

    logic CLOCK;
    logic RESET;

    tlc_sensor_timer_if bus();

    tlc_sensor_timer #(
        .DEB_CYCLES (4),
        .GREEN_MIN  (10),
        .YELLOW_CYC (3),
        .HLEFT_CYC  (5),
        .FLEFT_CYC  (6),
        .MAX_GREEN  (20),
        .CNT_W      (16)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [4:0] lamps;   // {HGREEN,HYELLOW,HLEFT,FLEFT,FYELLOW}
        bit         hwy;
        int         cycles;
        int         hs_from; // counter value where HS rises, -1 never
        int         fs_from;
    } vec_t;

    typedef struct {
        logic hs;
        logic fs;
        logic pend;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %b required %b", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_lamps(input logic [4:0] l);
        {bus.HGREEN, bus.HYELLOW, bus.HLEFT, bus.FLEFT, bus.FYELLOW} = l;
    endtask

    task automatic gap(input bit hwy);
        set_lamps(5'b00000);
        bus.HWY_CAR_RAW = hwy;
        repeat (8) step();
    endtask

    // Applies lamps, checks the lamp-change cycle, then one scoreboard entry
    // per cycle. Entry j corresponds to phase counter value j.
    task automatic run_phase(input logic [4:0] lamps, input int cycles,
                             input int hs_from, input int fs_from,
                             input bit pend, input string tag);
        exp_t e;
        exp_t got;
        set_lamps(lamps);
        #1;
        chk($sformatf("%s_switch_hs", tag), bus.HS, 1'b0);
        chk($sformatf("%s_switch_fs", tag), bus.FS, 1'b0);
        for (int j = 0; j < cycles; j++) begin
            e.hs   = (hs_from >= 0) && (j >= hs_from);
            e.fs   = (fs_from >= 0) && (j >= fs_from);
            e.pend = pend;
            sbq.push_back(e);
            step();
            got = sbq.pop_front();
            chk($sformatf("%s_hs_c%0d", tag, j), bus.HS, got.hs);
            chk($sformatf("%s_fs_c%0d", tag, j), bus.FS, got.fs);
            chk($sformatf("%s_pend_c%0d", tag, j), bus.FARM_PENDING, got.pend);
        end
    endtask

    initial begin
        vecs[0]  = '{5'b10000, 1'b1, 14, 10, -1};
        vecs[1]  = '{5'b10000, 1'b0, 14, -1, -1};
        vecs[2]  = '{5'b01000, 1'b0,  6,  3, -1};
        vecs[3]  = '{5'b00100, 1'b0,  8,  5, -1};
        vecs[4]  = '{5'b00010, 1'b0,  9,  6, -1};
        vecs[5]  = '{5'b00001, 1'b0,  6,  3, -1};
        vecs[6]  = '{5'b11001, 1'b0, 14, -1, -1};
        vecs[7]  = '{5'b01110, 1'b0,  6,  3, -1};
        vecs[8]  = '{5'b00111, 1'b0,  8,  5, -1};
        vecs[9]  = '{5'b00011, 1'b0,  9,  6, -1};
        vecs[10] = '{5'b10100, 1'b1, 13, 10, -1};

        RESET = 1'b1;
        bus.HWY_CAR_RAW  = 1'b0;
        bus.FARM_CAR_RAW = 1'b0;
        set_lamps(5'b00000);
        repeat (3) step();
        chk("reset_hs", bus.HS, 1'b0);
        chk("reset_fs", bus.FS, 1'b0);
        chk("reset_pend", bus.FARM_PENDING, 1'b0);
        RESET = 1'b0;

        // Phase timing and lamp priority table.
        for (int v = 0; v < 11; v++) begin
            gap(vecs[v].hwy);
            run_phase(vecs[v].lamps, vecs[v].cycles, vecs[v].hs_from,
                      vecs[v].fs_from, 1'b0, $sformatf("vec%0d", v));
        end

        // Bouncing farm sensor, then a clean level.
        gap(1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.FARM_CAR_RAW = ((i / 2) % 2) == 0;
            step();
            chk($sformatf("bounce_pend_%0d", i), bus.FARM_PENDING, 1'b0);
        end
        bus.FARM_CAR_RAW = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("settle_pend_%0d", k), bus.FARM_PENDING, k == 6);
        end

        // Green with farm request, then highway yellow.
        run_phase(5'b10000, 12, -1, 10, 1'b1, "s3_green");
        run_phase(5'b01000,  5,  3,  3, 1'b1, "s3_hyel");

        // Farm left, then farm yellow clears the request.
        run_phase(5'b00010,  8,  6,  6, 1'b1, "s4_fleft");
        run_phase(5'b00001,  5,  3, -1, 1'b0, "s4_fyel");

        // Reset in the middle of green.
        bus.FARM_CAR_RAW = 1'b0;
        gap(1'b0);
        bus.FARM_CAR_RAW = 1'b1;
        gap(1'b1);
        chk("s5_pend_before", bus.FARM_PENDING, 1'b1);
        set_lamps(5'b10000);
        repeat (8) step();
        RESET = 1'b1;
        bus.FARM_CAR_RAW = 1'b0;
        #1;
        chk("s5_rst_hs", bus.HS, 1'b0);
        chk("s5_rst_fs", bus.FS, 1'b0);
        chk("s5_rst_pend", bus.FARM_PENDING, 1'b0);
        repeat (2) step();
        RESET = 1'b0;
        run_phase(5'b10000, 13, 10, -1, 1'b0, "s5_green");

        // Silent highway in green.
        gap(1'b0);
`ifdef TLC_MAX_GREEN_EN
        run_phase(5'b10000, 24, 20, -1, 1'b0, "s6_maxg");
`else
        run_phase(5'b10000, 101, -1, -1, 1'b0, "s6_hold");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
